// File: rtl/mqnic_l2_pause_gen.sv
// -----------------------------------------------------------------------------
// mqnic_l2_pause_gen
//
// Flow-control frame generator for the MCF interface of mqnic_l2_egress.
// Watches the receive FIFO fill level against XOFF/XON watermarks with
// hysteresis. It sends an XOFF pause frame when the FIFO congests, and resends
// that XOFF periodically while congestion lasts. It sends an XON frame
// (quanta 0) once the FIFO drains.
//
// Build option:
//   MQNIC_PAUSE_GEN_PFC_EN  defined   -> priority flow control (opcode 0x0101,
//                                        per-class quanta from cfg_prio_mask)
//                           undefined -> link-level pause only (opcode 0x0001),
//                                        cfg_prio_mask ignored
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   fill_level        current RX FIFO occupancy
//   cfg_enable        flow-control enable
//   cfg_xoff_thresh   enter pause when fill_level >= threshold
//   cfg_xon_thresh    leave pause when fill_level <= threshold
//   cfg_quanta        pause quanta carried by XOFF frames
//   cfg_refresh       XOFF resend interval in cycles (0 = never resend)
//   cfg_eth_src       source MAC, latched when a frame is built
//   cfg_prio_mask     PFC class-enable vector
//   mcf_*             MCF descriptor (valid/ready handshake, fields held
//                     stable while valid is high)
//   paused            high from XOFF issue until XON acceptance
//   stat_xoff/xon     one-cycle pulse per accepted XOFF / XON
// -----------------------------------------------------------------------------
module mqnic_l2_pause_gen #(
  parameter int FILL_WIDTH      = 16,
  parameter int REFRESH_WIDTH   = 16,
  parameter int MCF_PARAMS_SIZE = 18,
  parameter int ID_WIDTH        = 8,
  parameter int DEST_WIDTH      = 8,
  parameter int USER_WIDTH      = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FILL_WIDTH-1:0]        fill_level,
  input  logic                         cfg_enable,
  input  logic [FILL_WIDTH-1:0]        cfg_xoff_thresh,
  input  logic [FILL_WIDTH-1:0]        cfg_xon_thresh,
  input  logic [15:0]                  cfg_quanta,
  input  logic [REFRESH_WIDTH-1:0]     cfg_refresh,
  input  logic [47:0]                  cfg_eth_src,
  input  logic [7:0]                   cfg_prio_mask,
  output logic                         mcf_valid,
  input  logic                         mcf_ready,
  output logic [47:0]                  mcf_eth_dst,
  output logic [47:0]                  mcf_eth_src,
  output logic [15:0]                  mcf_eth_type,
  output logic [15:0]                  mcf_opcode,
  output logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,
  output logic [ID_WIDTH-1:0]          mcf_id,
  output logic [DEST_WIDTH-1:0]        mcf_dest,
  output logic [USER_WIDTH-1:0]        mcf_user,
  output logic                         paused,
  output logic                         stat_xoff,
  output logic                         stat_xon
);

  localparam int PW = MCF_PARAMS_SIZE * 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XOFF_TX = 2'd1,
    PAUSED  = 2'd2,
    XON_TX  = 2'd3
  } state_t;

  state_t                   state_r;
  logic                     xoff_cond_r;
  logic                     xon_cond_r;
  logic [REFRESH_WIDTH-1:0] refresh_cnt_r;

  // Assemble the parameter field. XON frames carry zero quanta.
`ifdef MQNIC_PAUSE_GEN_PFC_EN
  function automatic logic [PW-1:0] build_params(input logic is_xon,
                                                 input logic [15:0] quanta,
                                                 input logic [7:0] mask);
    logic [PW-1:0] p;
    p = '0;
    p[15:8] = mask;
    for (int i = 0; i < 8; i++) begin
      // Class i quanta is big-endian in bytes 2+2i / 3+2i.
      if (!is_xon && mask[i] && ((3 + 2 * i) < MCF_PARAMS_SIZE)) begin
        p[(2 + 2 * i) * 8 +: 8] = quanta[15:8];
        p[(3 + 2 * i) * 8 +: 8] = quanta[7:0];
      end
    end
    return p;
  endfunction

  assign mcf_opcode = 16'h0101;
`else
  function automatic logic [PW-1:0] build_params(input logic is_xon,
                                                 input logic [15:0] quanta);
    logic [PW-1:0] p;
    p = '0;
    if (!is_xon) begin
      p[7:0]  = quanta[15:8];
      p[15:8] = quanta[7:0];
    end
    return p;
  endfunction

  // Link-level pause has no class vector.
  logic unused_prio_s;
  assign unused_prio_s = ^cfg_prio_mask;

  assign mcf_opcode = 16'h0001;
`endif

  // Fixed descriptor fields.
  assign mcf_eth_dst  = 48'h0180C2000001;
  assign mcf_eth_type = 16'h8808;
  assign mcf_id       = '0;
  assign mcf_dest     = '0;
  assign mcf_user     = '0;

  // Register the watermark comparisons. A crossing sampled here reaches the
  // FSM one edge later. Disabling flow control counts as a drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xoff_cond_r <= 1'b0;
      xon_cond_r  <= 1'b0;
    end else begin
      xoff_cond_r <= cfg_enable && (fill_level >= cfg_xoff_thresh);
      xon_cond_r  <= !cfg_enable || (fill_level <= cfg_xon_thresh);
    end
  end

  // Pause FSM. It owns every registered output. Once mcf_valid is raised it
  // only falls on acceptance. Condition changes while a frame is pending are
  // acted on from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      refresh_cnt_r <= '0;
      mcf_valid     <= 1'b0;
      mcf_eth_src   <= 48'h0;
      mcf_params    <= '0;
      paused        <= 1'b0;
      stat_xoff     <= 1'b0;
      stat_xon      <= 1'b0;
    end else begin
      stat_xoff <= 1'b0;
      stat_xon  <= 1'b0;
      case (state_r)
        IDLE: begin
          // XOFF takes precedence here even if the XON condition also holds.
          if (xoff_cond_r) begin
            mcf_valid   <= 1'b1;
            mcf_eth_src <= cfg_eth_src;
`ifdef MQNIC_PAUSE_GEN_PFC_EN
            mcf_params  <= build_params(1'b0, cfg_quanta, cfg_prio_mask);
`else
            mcf_params  <= build_params(1'b0, cfg_quanta);
`endif
            paused      <= 1'b1;
            state_r     <= XOFF_TX;
          end
        end
        XOFF_TX: begin
          if (mcf_ready) begin
            mcf_valid     <= 1'b0;
            stat_xoff     <= 1'b1;
            refresh_cnt_r <= cfg_refresh;
            state_r       <= PAUSED;
          end
        end
        PAUSED: begin
          // Drain or disable wins over a due refresh.
          if (xon_cond_r) begin
            mcf_valid     <= 1'b1;
            mcf_eth_src   <= cfg_eth_src;
`ifdef MQNIC_PAUSE_GEN_PFC_EN
            mcf_params    <= build_params(1'b1, cfg_quanta, cfg_prio_mask);
`else
            mcf_params    <= build_params(1'b1, cfg_quanta);
`endif
            refresh_cnt_r <= '0;
            state_r       <= XON_TX;
          end else if (refresh_cnt_r == REFRESH_WIDTH'(1)) begin
            mcf_valid     <= 1'b1;
            mcf_eth_src   <= cfg_eth_src;
`ifdef MQNIC_PAUSE_GEN_PFC_EN
            mcf_params    <= build_params(1'b0, cfg_quanta, cfg_prio_mask);
`else
            mcf_params    <= build_params(1'b0, cfg_quanta);
`endif
            refresh_cnt_r <= '0;
            state_r       <= XOFF_TX;
          end else if (refresh_cnt_r != '0) begin
            refresh_cnt_r <= refresh_cnt_r - REFRESH_WIDTH'(1);
          end
        end
        XON_TX: begin
          if (mcf_ready) begin
            mcf_valid <= 1'b0;
            stat_xon  <= 1'b1;
            paused    <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          mcf_valid     <= 1'b0;
          paused        <= 1'b0;
          refresh_cnt_r <= '0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule
